// File: rtl/julia_pixel_iterator.sv
// julia_pixel_iterator
//   Iteration controller for one Julia-set pixel. Takes a job (z0, c) over a
//   valid/ready handshake, drives an external combinational z_calculator with
//   the registered z, c and iteration count k, feeds the returned z back each
//   cycle until |z|^2 escapes or the iteration cap is hit, then offers
//   (iterations, escaped) over a second valid/ready handshake.
//
//   Optional build macro: JULIA_ITER_CHECK_EN
//     Compares the calculator's iteration passthrough against k every ITER
//     cycle. A mismatch sets the sticky iter_error flag and forces a capped
//     result carrying the current k. Without the macro the passthrough is
//     ignored and iter_error is tied low.

module julia_pixel_iterator #(
  parameter int WIDTH        = 22,
  parameter int FRACTIONAL   = 11,
  parameter int INTEGRAL     = 11,
  parameter int MAX_ITER     = 255,
  parameter int ESCAPE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  // job intake
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] z0_real,
  input  logic [WIDTH-1:0] z0_imag,
  input  logic [WIDTH-1:0] c_real,
  input  logic [WIDTH-1:0] c_imag,
  // to z_calculator
  output logic [WIDTH-1:0] calc_z_real_out,
  output logic [WIDTH-1:0] calc_z_imag_out,
  output logic [WIDTH-1:0] calc_c_real_out,
  output logic [WIDTH-1:0] calc_c_imag_out,
  output logic [7:0]       calc_iteration_out,
  // from z_calculator
  input  logic [WIDTH-1:0] calc_z_real_in,
  input  logic [WIDTH-1:0] calc_z_imag_in,
  input  logic [WIDTH-1:0] calc_size_squared_in,
  input  logic [7:0]       calc_iteration_in,
  // result delivery
  output logic             result_valid,
  input  logic             result_ready,
  output logic [7:0]       result_iterations,
  output logic             result_escaped,
  output logic             iter_error
);

  // Elaboration-time parameter sanity checks.
  if (WIDTH != FRACTIONAL + INTEGRAL) begin : g_bad_width
    $error("julia_pixel_iterator: WIDTH must equal FRACTIONAL + INTEGRAL");
  end
  if (MAX_ITER < 1 || MAX_ITER > 255) begin : g_bad_max_iter
    $error("julia_pixel_iterator: MAX_ITER must be in 1..255");
  end

  localparam logic signed [WIDTH-1:0] ESCAPE_THRESHOLD = WIDTH'(ESCAPE_LIMIT << FRACTIONAL);
  localparam logic [7:0]              MAX_ITER_K       = 8'(MAX_ITER);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_z_real;
  logic [WIDTH-1:0] r_z_imag;
  logic [WIDTH-1:0] r_c_real;
  logic [WIDTH-1:0] r_c_imag;
  logic [7:0]       r_k;
  logic [7:0]       r_result_iterations;
  logic             r_result_escaped;

  logic [7:0]       w_k_next;
  logic             w_escape;
  logic             w_capped;
  logic             w_mismatch;
  logic             w_accept;

  assign w_k_next = r_k + 8'd1;
  assign w_accept = start_valid && (r_state == S_IDLE);

  // A negative |z|^2 means the calculator overflowed, which is treated as an
  // escape. Equality with the threshold is not an escape.
  assign w_escape = calc_size_squared_in[WIDTH-1] ||
                    ($signed(calc_size_squared_in) > ESCAPE_THRESHOLD);
  assign w_capped = (w_k_next == MAX_ITER_K);

`ifdef JULIA_ITER_CHECK_EN
  logic r_iter_error;

  assign w_mismatch = (calc_iteration_in != r_k);
  assign iter_error = r_iter_error;

  // Sticky passthrough-mismatch flag; only reset clears it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_iter_error <= 1'b0;
    end else if (r_state == S_ITER && w_mismatch) begin
      r_iter_error <= 1'b1;
    end
  end
`else
  logic w_unused_iteration;

  assign w_mismatch         = 1'b0;
  assign iter_error         = 1'b0;
  assign w_unused_iteration = &{1'b0, calc_iteration_in};
`endif

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake decode; handshakes depend on state only.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    w_next_state = r_state;
    start_ready  = 1'b0;
    result_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) w_next_state = S_ITER;
      end
      S_ITER: begin
        if (w_mismatch || w_escape || w_capped) w_next_state = S_DONE;
      end
      S_DONE: begin
        result_valid = 1'b1;
        if (result_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Job registers, iteration count and result capture.
  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: every register here is a plain flop (no memory array), so all of
    // them reset; an aborted job leaves nothing behind.
    if (!n_rst) begin
      r_z_real            <= '0;
      r_z_imag            <= '0;
      r_c_real            <= '0;
      r_c_imag            <= '0;
      r_k                 <= '0;
      r_result_iterations <= '0;
      r_result_escaped    <= 1'b0;
    end else if (w_accept) begin
      r_z_real <= z0_real;
      r_z_imag <= z0_imag;
      r_c_real <= c_real;
      r_c_imag <= c_imag;
      r_k      <= '0;
    end else if (r_state == S_ITER) begin
      if (w_mismatch) begin
        r_result_iterations <= r_k;
        r_result_escaped    <= 1'b0;
      end else if (w_escape) begin
        r_result_iterations <= w_k_next;
        r_result_escaped    <= 1'b1;
      end else if (w_capped) begin
        r_result_iterations <= MAX_ITER_K;
        r_result_escaped    <= 1'b0;
      end else begin
        r_z_real <= calc_z_real_in;
        r_z_imag <= calc_z_imag_in;
        r_k      <= w_k_next;
      end
    end
  end

  assign calc_z_real_out    = r_z_real;
  assign calc_z_imag_out    = r_z_imag;
  assign calc_c_real_out    = r_c_real;
  assign calc_c_imag_out    = r_c_imag;
  assign calc_iteration_out = r_k;
  assign result_iterations  = r_result_iterations;
  assign result_escaped     = r_result_escaped;

endmodule

// File: tb/tb_julia_pixel_iterator.sv
// tb_julia_pixel_iterator
//   Directed bench for julia_pixel_iterator at 22/11/11, MAX_ITER = 255.
//   A behavioural z_calculator (z^2 + c, floor-shifted fixed point, wrapped
//   to WIDTH) closes the loop; a size override and an iteration-passthrough
//   corruption control reach the corner cases the arithmetic cannot hit cleanly.
//   Build with JULIA_ITER_CHECK_EN to include the passthrough-mismatch case.

module tb_julia_pixel_iterator;

  localparam int W = 22;
  localparam int F = 11;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] z0_real = '0, z0_imag = '0, c_real = '0, c_imag = '0;
  logic [W-1:0] calc_z_real_out, calc_z_imag_out, calc_c_real_out, calc_c_imag_out;
  logic [7:0]   calc_iteration_out;
  logic [W-1:0] calc_z_real_in, calc_z_imag_in, calc_size_squared_in;
  logic [7:0]   calc_iteration_in;
  logic         result_valid;
  logic         result_ready = 1'b0;
  logic [7:0]   result_iterations;
  logic         result_escaped;
  logic         iter_error;

  int checks   = 0;
  int failures = 0;

  // stimulus controls for the calculator model
  logic         ovr_en  = 1'b0;
  logic [7:0]   ovr_k   = '0;
  logic [W-1:0] ovr_val = '0;
  logic         corrupt = 1'b0;
  logic         exp_err = 1'b0;

  julia_pixel_iterator #(
    .WIDTH(W), .FRACTIONAL(F), .INTEGRAL(11), .MAX_ITER(255), .ESCAPE_LIMIT(4)
  ) dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .start_valid         (start_valid),
    .start_ready         (start_ready),
    .z0_real             (z0_real),
    .z0_imag             (z0_imag),
    .c_real              (c_real),
    .c_imag              (c_imag),
    .calc_z_real_out     (calc_z_real_out),
    .calc_z_imag_out     (calc_z_imag_out),
    .calc_c_real_out     (calc_c_real_out),
    .calc_c_imag_out     (calc_c_imag_out),
    .calc_iteration_out  (calc_iteration_out),
    .calc_z_real_in      (calc_z_real_in),
    .calc_z_imag_in      (calc_z_imag_in),
    .calc_size_squared_in(calc_size_squared_in),
    .calc_iteration_in   (calc_iteration_in),
    .result_valid        (result_valid),
    .result_ready        (result_ready),
    .result_iterations   (result_iterations),
    .result_escaped      (result_escaped),
    .iter_error          (iter_error)
  );

  always #5 clk = ~clk;

  // Behavioural combinational z_calculator: z' = z^2 + c, size = |z'|^2.
  logic signed [63:0] m_zr, m_zi, m_cr, m_ci, m_nr, m_ni, m_tr, m_ti, m_sz;
  always_comb begin
    m_zr = 64'($signed(calc_z_real_out));
    m_zi = 64'($signed(calc_z_imag_out));
    m_cr = 64'($signed(calc_c_real_out));
    m_ci = 64'($signed(calc_c_imag_out));
    m_nr = ((m_zr * m_zr - m_zi * m_zi) >>> F) + m_cr;
    m_ni = ((64'sd2 * m_zr * m_zi) >>> F) + m_ci;
    m_tr = 64'($signed(m_nr[W-1:0]));
    m_ti = 64'($signed(m_ni[W-1:0]));
    m_sz = (m_tr * m_tr + m_ti * m_ti) >>> F;
    calc_z_real_in       = m_nr[W-1:0];
    calc_z_imag_in       = m_ni[W-1:0];
    calc_size_squared_in = m_sz[W-1:0];
    if (ovr_en && calc_iteration_out == ovr_k) calc_size_squared_in = ovr_val;
    calc_iteration_in = calc_iteration_out;
    if (corrupt && calc_iteration_out == 8'd2) calc_iteration_in = calc_iteration_out + 8'd3;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    string        name;
    logic [W-1:0] z0r, z0i, cr, ci;
    logic         ovr_en;
    logic [7:0]   ovr_k;
    logic [W-1:0] ovr_val;
    logic [7:0]   exp_iter;
    logic         exp_esc;
  } vec_t;

  // Offer a job, wait (bounded) for the result, check it, then handshake.
  task automatic run_job(input vec_t v, input int exp_lat);
    int lat;
    @(negedge clk);
    ovr_en = v.ovr_en; ovr_k = v.ovr_k; ovr_val = v.ovr_val;
    z0_real = v.z0r; z0_imag = v.z0i; c_real = v.cr; c_imag = v.ci;
    start_valid = 1'b1;
    check({v.name, " start_ready"}, 32'(start_ready), 32'd1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    lat = 0;
    while (!result_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    check({v.name, " latency"},    32'(lat), 32'(exp_lat));
    check({v.name, " iterations"}, 32'(result_iterations), 32'(v.exp_iter));
    check({v.name, " escaped"},    32'(result_escaped), 32'(v.exp_esc));
    check({v.name, " iter_error"}, 32'(iter_error), 32'(exp_err));
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    check({v.name, " valid drop"}, 32'(result_valid), 32'd0);
    ovr_en = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n;
    logic seen_valid;

    // z0/c in Q11.11; 2048 = 1.0
    vecs[0] = '{"spiral",   22'sd2048, 22'sd1024, -22'sd1024, 22'sd1024, 1'b0, 8'd0, '0, 8'd2,   1'b1};
    vecs[1] = '{"zero",     '0, '0, '0, '0,                            1'b0, 8'd0, '0, 8'd255, 1'b0};
    vecs[2] = '{"edge4",    '0, '0, 22'sd4096, '0,                     1'b0, 8'd0, '0, 8'd2,   1'b1};
    vecs[3] = '{"first",    22'sd4096, 22'sd4096, '0, '0,              1'b0, 8'd0, '0, 8'd1,   1'b1};
    vecs[4] = '{"cycle2",   '0, '0, -22'sd2048, '0,                    1'b0, 8'd0, '0, 8'd255, 1'b0};
    vecs[5] = '{"negsize",  '0, '0, '0, '0, 1'b1, 8'd3, 22'h3FFFFF,    8'd4,   1'b1};
    vecs[6] = '{"above",    '0, '0, '0, '0, 1'b1, 8'd0, 22'd8193,      8'd1,   1'b1};
    vecs[7] = '{"atlimit",  '0, '0, '0, '0, 1'b1, 8'd0, 22'd8192,      8'd255, 1'b0};

    // reset values
    #3;
    check("rst start_ready",  32'(start_ready), 32'd1);
    check("rst result_valid", 32'(result_valid), 32'd0);
    check("rst iterations",   32'(result_iterations), 32'd0);
    check("rst escaped",      32'(result_escaped), 32'd0);
    check("rst iter_error",   32'(iter_error), 32'd0);
    check("rst calc_z",       32'({calc_z_real_out, calc_z_imag_out} != '0), 32'd0);
    check("rst calc_c_k",     32'({calc_c_real_out, calc_c_imag_out, calc_iteration_out} != '0), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < 8; i++) run_job(vecs[i], int'(vecs[i].exp_iter));

    // backpressure: hold DONE with start_valid asserted
    v = vecs[0];
    @(negedge clk);
    z0_real = v.z0r; z0_imag = v.z0i; c_real = v.cr; c_imag = v.ci;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    n = 0;
    while (!result_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp reach done", 32'(result_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start_valid = 1'b1;
      z0_real = 22'sd4096; z0_imag = 22'sd4096; c_real = '0; c_imag = '0;
      check("bp hold", 32'({result_valid, start_ready, result_escaped, result_iterations}),
            32'({1'b1, 1'b0, 1'b1, 8'd2}));
    end
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    check("bp idle start_ready",  32'(start_ready), 32'd1);
    check("bp idle result_valid", 32'(result_valid), 32'd0);
    @(posedge clk); #1;
    start_valid = 1'b0;
    check("bp accepted", 32'({start_ready, calc_iteration_out}), 32'({1'b0, 8'd0}));
    check("bp new z0",   32'(calc_z_real_out), 32'd4096);
    @(posedge clk); #1;
    check("bp next result", 32'({result_valid, result_escaped, result_iterations}),
          32'({1'b1, 1'b1, 8'd1}));
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;

    // reset while iterating at k = 5
    @(negedge clk);
    z0_real = '0; z0_imag = '0; c_real = '0; c_imag = '0;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    n = 0;
    while (calc_iteration_out != 8'd5 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort at k5", 32'(calc_iteration_out), 32'd5);
    #2;
    n_rst = 1'b0;
    #1;
    check("abort start_ready", 32'(start_ready), 32'd1);
    check("abort outputs", 32'({result_valid, result_escaped, result_iterations, iter_error}), 32'd0);
    check("abort calc", 32'({calc_z_real_out, calc_z_imag_out, calc_c_real_out,
                             calc_c_imag_out, calc_iteration_out} != '0), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen_valid = seen_valid | result_valid;
    end
    check("abort no result",   32'(seen_valid), 32'd0);
    check("abort ready after", 32'(start_ready), 32'd1);

`ifdef JULIA_ITER_CHECK_EN
    // passthrough returns k+3 at k = 2: error result carries k, flag sticks
    corrupt = 1'b1;
    exp_err = 1'b1;
    v = vecs[1];
    v.name = "mismatch";
    v.exp_iter = 8'd2;
    v.exp_esc = 1'b0;
    run_job(v, 3);
    corrupt = 1'b0;
    run_job(vecs[3], 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
